nodf_module_intf_core: RTL and testbench

//  Synthesizable handshake monitor for one non-dataflow HLS block (ap_ctrl_hs/ap_ctrl_chain).

---
 rtl/nodf_module_intf_core.sv | 161 ++++++++++++++++
 tb/tb_nodf_module_intf_core.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/nodf_module_intf_core.sv
// Handshake monitor for one non-dataflow HLS block.
// Tracks ap_ctrl state, transaction counts, stalls, latency and interval.
module nodf_module_intf_core #(
  parameter int CNT_W = 32
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             ap_start,
  input  logic             ap_ready,
  input  logic             ap_done,
  input  logic             ap_continue,
  input  logic             finish,
  output logic [1:0]       state,
  output logic             busy,
  output logic [CNT_W-1:0] start_cnt,
  output logic [CNT_W-1:0] ready_cnt,
  output logic [CNT_W-1:0] done_cnt,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] last_latency,
  output logic [CNT_W-1:0] last_interval,
  output logic             err_done_idle
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_WAIT = 2'd2;
  localparam logic [1:0] S_FIN  = 2'd3;

  localparam logic [CNT_W-1:0] ONE = CNT_W'(1);

  logic [1:0]       state_q, state_d;
  logic             busy_q, busy_d;
  logic [CNT_W-1:0] start_q, start_d;
  logic [CNT_W-1:0] ready_q, ready_d;
  logic [CNT_W-1:0] done_q, done_d;
  logic [CNT_W-1:0] stall_q, stall_d;
  logic [CNT_W-1:0] lat_q, lat_d;
  logic [CNT_W-1:0] intv_q, intv_d;
  logic [CNT_W-1:0] lat_run_q, lat_run_d;
  logic [CNT_W-1:0] int_run_q, int_run_d;
  logic             seen_q, seen_d;
  logic             err_q, err_d;
  logic             start_ev;

  assign start_ev = ap_start && ap_ready;

  // Next-state: FSM, counters and timing; all frozen once FINISHED.
  always_comb begin
    state_d   = state_q;
    start_d   = start_q;
    ready_d   = ready_q;
    done_d    = done_q;
    stall_d   = stall_q;
    lat_d     = lat_q;
    intv_d    = intv_q;
    lat_run_d = lat_run_q;
    int_run_d = int_run_q;
    seen_d    = seen_q;
    err_d     = err_q;
    if (state_q != S_FIN) begin
      if (finish) begin
        state_d = S_FIN;
      end else begin
        if (start_ev) start_d = start_q + ONE;
        if (ap_ready) ready_d = ready_q + ONE;
        if (ap_done && ap_continue) done_d = done_q + ONE;
        if (ap_done && !ap_continue) stall_d = stall_q + ONE;
        if (start_ev) begin
          seen_d    = 1'b1;
          int_run_d = '0;
          if (seen_q) intv_d = int_run_q + ONE;
        end else begin
          int_run_d = int_run_q + ONE;
        end
        // lat_run counts the start cycle itself, hence reload with 1.
        unique case (state_q)
          S_IDLE: begin
            if (ap_start) begin
              if (ap_done) begin
                lat_d   = '0;
                state_d = ap_continue ? S_IDLE : S_WAIT;
              end else begin
                state_d   = S_RUN;
                lat_run_d = ONE;
              end
            end else if (ap_done) begin
              err_d = 1'b1;
            end
          end
          S_RUN: begin
            lat_run_d = lat_run_q + ONE;
            if (ap_done) begin
              lat_d = lat_run_q + ONE;
              if (!ap_continue) begin
                state_d = S_WAIT;
              end else if (ap_start) begin
                lat_run_d = ONE;
              end else begin
                state_d = S_IDLE;
              end
            end
          end
          S_WAIT: begin
            if (ap_continue) begin
              if (ap_start) begin
                state_d   = S_RUN;
                lat_run_d = ONE;
              end else begin
                state_d = S_IDLE;
              end
            end
          end
          default: ;
        endcase
      end
    end
    busy_d = (state_d == S_RUN) || (state_d == S_WAIT);
  end

  // State registers with synchronous active-high reset.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q   <= S_IDLE;
      busy_q    <= 1'b0;
      start_q   <= '0;
      ready_q   <= '0;
      done_q    <= '0;
      stall_q   <= '0;
      lat_q     <= '0;
      intv_q    <= '0;
      lat_run_q <= '0;
      int_run_q <= '0;
      seen_q    <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      busy_q    <= busy_d;
      start_q   <= start_d;
      ready_q   <= ready_d;
      done_q    <= done_d;
      stall_q   <= stall_d;
      lat_q     <= lat_d;
      intv_q    <= intv_d;
      lat_run_q <= lat_run_d;
      int_run_q <= int_run_d;
      seen_q    <= seen_d;
      err_q     <= err_d;
    end
  end

  assign state         = state_q;
  assign busy          = busy_q;
  assign start_cnt     = start_q;
  assign ready_cnt     = ready_q;
  assign done_cnt      = done_q;
  assign stall_cnt     = stall_q;
  assign last_latency  = lat_q;
  assign last_interval = intv_q;
  assign err_done_idle = err_q;

endmodule

// File: tb/tb_nodf_module_intf_core.sv
// Bench for nodf_module_intf_core.
// Directed handshake scenarios plus random traffic vs timestamp model.
module tb_nodf_module_intf_core;

  logic        clock = 1'b0;
  logic        reset;
  logic        ap_start, ap_ready, ap_done, ap_continue, finish;
  logic [1:0]  state;
  logic        busy;
  logic [31:0] start_cnt, ready_cnt, done_cnt, stall_cnt;
  logic [31:0] last_latency, last_interval;
  logic        err_done_idle;

  nodf_module_intf_core #(.CNT_W(32)) dut (
    .clock        (clock),
    .reset        (reset),
    .ap_start     (ap_start),
    .ap_ready     (ap_ready),
    .ap_done      (ap_done),
    .ap_continue  (ap_continue),
    .finish       (finish),
    .state        (state),
    .busy         (busy),
    .start_cnt    (start_cnt),
    .ready_cnt    (ready_cnt),
    .done_cnt     (done_cnt),
    .stall_cnt    (stall_cnt),
    .last_latency (last_latency),
    .last_interval(last_interval),
    .err_done_idle(err_done_idle)
  );

  always #5 clock = ~clock;

  int n_chk  = 0;
  int n_pass = 0;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
  endtask

  // Reference model: mode plus cycle timestamps.
  int          cyc;
  int          m_mode;
  int          t_start;
  int          t_prev;
  bit          have_prev;
  bit          m_err;
  logic [31:0] m_start, m_ready, m_done, m_stall, m_lat, m_int;

  task automatic model_clear();
    m_mode = 0; t_start = 0; t_prev = 0; have_prev = 0; m_err = 0;
    m_start = 0; m_ready = 0; m_done = 0; m_stall = 0;
    m_lat = 0; m_int = 0;
  endtask

  task automatic model_step();
    bit s, r, d, c;
    s = ap_start; r = ap_ready; d = ap_done; c = ap_continue;
    cyc++;
    if (reset) begin
      model_clear();
    end else if (m_mode == 3) begin
    end else if (finish) begin
      m_mode = 3;
    end else begin
      if (s && r) begin
        m_start++;
        if (have_prev) m_int = cyc - t_prev;
        t_prev = cyc;
        have_prev = 1;
      end
      if (r) m_ready++;
      if (d && c) m_done++;
      if (d && !c) m_stall++;
      case (m_mode)
        0: if (s) begin
             if (d) begin
               m_lat = 0;
               m_mode = c ? 0 : 2;
             end else begin
               m_mode = 1;
               t_start = cyc;
             end
           end else if (d) m_err = 1;
        1: if (d) begin
             m_lat = cyc - t_start + 1;
             if (!c) m_mode = 2;
             else if (s) t_start = cyc;
             else m_mode = 0;
           end
        2: if (c) begin
             if (s) begin
               m_mode = 1;
               t_start = cyc;
             end else m_mode = 0;
           end
        default: ;
      endcase
    end
  endtask

  task automatic cmp_all();
    chk("state", 32'(state), 32'(m_mode));
    chk("busy", 32'(busy), 32'(m_mode == 1 || m_mode == 2));
    chk("start_cnt", start_cnt, m_start);
    chk("ready_cnt", ready_cnt, m_ready);
    chk("done_cnt", done_cnt, m_done);
    chk("stall_cnt", stall_cnt, m_stall);
    chk("last_latency", last_latency, m_lat);
    chk("last_interval", last_interval, m_int);
    chk("err_done_idle", 32'(err_done_idle), 32'(m_err));
  endtask

  task automatic drv(input bit s, input bit r, input bit d, input bit c,
                     input bit f, input bit rst);
    ap_start = s; ap_ready = r; ap_done = d;
    ap_continue = c; finish = f; reset = rst;
    @(posedge clock);
    model_step();
    @(negedge clock);
    cmp_all();
  endtask

  task automatic do_reset();
    drv(0, 0, 0, 0, 0, 1);
    drv(0, 0, 0, 1, 0, 0);
  endtask

  initial begin
    cyc = 0;
    model_clear();
    ap_start = 0; ap_ready = 0; ap_done = 0;
    ap_continue = 0; finish = 0; reset = 1;
    @(negedge clock);
    drv(0, 0, 0, 0, 0, 1);
    chk("rst_state", 32'(state), 32'd0);
    chk("rst_start", start_cnt, 32'd0);

    // Single transaction: start@2, done@6.
    do_reset();
    drv(1, 1, 0, 1, 0, 0);
    repeat (3) drv(0, 0, 0, 1, 0, 0);
    drv(0, 0, 1, 1, 0, 0);
    chk("t1_lat", last_latency, 32'd5);
    chk("t1_start", start_cnt, 32'd1);
    chk("t1_done", done_cnt, 32'd1);
    chk("t1_state", 32'(state), 32'd0);

    // Back-to-back with start held.
    do_reset();
    for (int k = 0; k < 16; k++)
      drv(k < 15, k == 0 || k == 8, k == 7 || k == 15, 1, 0, 0);
    chk("t2_start", start_cnt, 32'd2);
    chk("t2_int", last_interval, 32'd8);
    chk("t2_state", 32'(state), 32'd0);

    // Done stalled by ap_continue=0 for 3 cycles.
    do_reset();
    drv(1, 1, 0, 1, 0, 0);
    repeat (2) drv(0, 0, 0, 1, 0, 0);
    for (int k = 0; k < 3; k++) begin
      drv(0, 0, 1, 0, 0, 0);
      chk("t3_wait", 32'(state), 32'd2);
    end
    drv(0, 0, 1, 1, 0, 0);
    chk("t3_stall", stall_cnt, 32'd3);
    chk("t3_done", done_cnt, 32'd1);
    chk("t3_state", 32'(state), 32'd0);

    // Done while idle without start.
    do_reset();
    drv(0, 0, 1, 0, 0, 0);
    repeat (3) drv(0, 0, 0, 1, 0, 0);
    chk("t4_err", 32'(err_done_idle), 32'd1);
    chk("t4_done", done_cnt, 32'd0);

    // Ready-only hookup.
    do_reset();
    repeat (4) begin
      drv(0, 1, 0, 0, 0, 0);
      drv(0, 0, 0, 0, 0, 0);
    end
    chk("t5_ready", ready_cnt, 32'd4);
    chk("t5_start", start_cnt, 32'd0);
    chk("t5_state", 32'(state), 32'd0);

    // Finish mid-run, stimulus continues, then reset.
    do_reset();
    drv(1, 1, 0, 1, 0, 0);
    repeat (2) drv(0, 0, 0, 1, 0, 0);
    drv(1, 1, 1, 1, 1, 0);
    repeat (10) drv(1'($urandom), 1'($urandom), 1'($urandom),
                    1'($urandom), 0, 0);
    chk("t6_state", 32'(state), 32'd3);
    chk("t6_start", start_cnt, 32'd1);
    chk("t6_done", done_cnt, 32'd0);
    drv(1, 1, 1, 1, 1, 1);
    chk("t6_rst_state", 32'(state), 32'd0);
    chk("t6_rst_ready", ready_cnt, 32'd0);

    // Random traffic.
    for (int rnd = 0; rnd < 4; rnd++) begin
      do_reset();
      for (int i = 0; i < 200; i++)
        drv($urandom_range(0, 99) < 40, $urandom_range(0, 99) < 35,
            $urandom_range(0, 99) < 25, $urandom_range(0, 99) < 70,
            i > 150 && $urandom_range(0, 99) < 3, 0);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
